word_serializer: RTL and testbench

- Parametrised successor to the fixed 16-to-1 byte lane mux.
- Captures one wide word through a valid/ready handshake, then emits a programmable number of lanes, one per transfer, on a narrow valid/ready stream.
- Lane order is selectable per word.
- Sits between wide datapath registers and narrow byte-stream sinks such as the UART TX and FIFO front ends.

---
 rtl/word_serializer_pkg.sv | 22 ++
 rtl/word_serializer_if.sv | 29 ++
 rtl/word_serializer_lane_mux.sv | 22 ++
 rtl/word_serializer.sv | 168 ++++++++++++++++
 tb/tb_word_serializer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state, default geometry
// and the mapping from a raw lane count to the effective lane count.
package word_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int unsigned DEF_LANE_W = 32'd8;
  localparam int unsigned DEF_LANES  = 32'd16;

  // A zero or oversized request means "the whole word".
  function automatic int unsigned eff_count(input int unsigned raw, input int unsigned lanes);
    if ((raw == 32'd0) || (raw > lanes)) begin
      return lanes;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Wide-word input handshake and narrow lane output stream of the word serializer.
// The slave modport is the serializer's view, the master modport the environment's.
interface word_serializer_if #(
  parameter int unsigned LANE_W = word_serializer_pkg::DEF_LANE_W,
  parameter int unsigned LANES  = word_serializer_pkg::DEF_LANES,
  parameter int unsigned CNT_W  = $clog2(LANES) + 1
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*LANE_W-1:0]  in_data;
  logic [CNT_W-1:0]         in_count;
  logic                     in_msb_first;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANE_W-1:0]        out_data;
  logic                     out_last;

  modport slave (
    input  in_valid, in_data, in_count, in_msb_first, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_count, in_msb_first, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/word_serializer_lane_mux.sv
// LANES-to-1 selector of LANE_W-bit lanes; an out-of-range select yields zero.
module lane_mux
  import word_serializer_pkg::*;
#(
  parameter int unsigned LANE_W = DEF_LANE_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned SEL_W  = $clog2(LANES)
) (
  input  logic [LANES*LANE_W-1:0] data_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [LANE_W-1:0]       lane_o
);

  // AND-OR selection keeps every select value defined, including non-power-of-two LANES.
  always_comb begin
    lane_o = {LANE_W{1'b0}};
    for (int k = 0; k < int'(LANES); k++) begin
      lane_o = lane_o | (data_i[k*LANE_W +: LANE_W] & {LANE_W{sel_i == SEL_W'(k)}});
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Captures a wide word and streams a programmable number of its lanes in either order.
// Optional out_parity port is enabled by defining WORD_SERIALIZER_PARITY_EN.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int unsigned LANE_W = DEF_LANE_W,
  parameter int unsigned LANES  = DEF_LANES,
  parameter int unsigned CNT_W  = $clog2(LANES) + 1
) (
  input  logic               clk,
  input  logic               nRst,
  word_serializer_if.slave   stream,
`ifdef WORD_SERIALIZER_PARITY_EN
  output logic               out_parity,
`endif
  output logic               busy
);

  localparam int unsigned SEL_W = CNT_W - 1;

  state_e                  state_q, state_d;
  logic [LANES*LANE_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]        n_q, n_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic                    msb_q, msb_d;

  logic                    send_s;
  logic                    last_s;
  logic                    xfer_s;
  logic                    in_ready_s;
  logic                    accept_s;
  logic [CNT_W-1:0]        n_in_s;
  logic [SEL_W-1:0]        sel_s;
  logic [LANE_W-1:0]       lane_s;

  // Physical lane for logical position idx: reversed within the first n lanes when msb-first.
  function automatic logic [SEL_W-1:0] lane_sel(input logic msb,
                                                input logic [CNT_W-1:0] n,
                                                input logic [CNT_W-1:0] idx);
    logic [CNT_W-1:0] pos;
    if (msb) begin
      pos = n - idx - CNT_W'(1'b1);
    end else begin
      pos = idx;
    end
    return pos[SEL_W-1:0];
  endfunction

  assign n_in_s     = CNT_W'(eff_count(32'(stream.in_count), LANES));
  assign send_s     = (state_q == SEND);
  assign last_s     = send_s && (idx_q == (n_q - CNT_W'(1'b1)));
  assign xfer_s     = send_s && stream.out_ready;
  assign in_ready_s = !send_s || (xfer_s && last_s);
  assign accept_s   = stream.in_valid && in_ready_s;
  assign sel_s      = lane_sel(msb_q, n_q, idx_q);

  lane_mux #(
    .LANE_W (LANE_W),
    .LANES  (LANES),
    .SEL_W  (SEL_W)
  ) u_lane_mux (
    .data_i (word_q),
    .sel_i  (sel_s),
    .lane_o (lane_s)
  );

  assign stream.in_ready  = in_ready_s;
  assign stream.out_valid = send_s;
  assign stream.out_last  = last_s;
  assign stream.out_data  = send_s ? lane_s : {LANE_W{1'b0}};
  assign busy             = send_s;

  // State and lane bookkeeping registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      word_q  <= {(LANES*LANE_W){1'b0}};
      n_q     <= {CNT_W{1'b0}};
      idx_q   <= {CNT_W{1'b0}};
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      msb_q   <= msb_d;
    end
  end

  // Next state: capture on acceptance (also on the last transfer for back-to-back words).
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    n_d     = n_q;
    idx_d   = idx_q;
    msb_d   = msb_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SEND;
          word_d  = stream.in_data;
          n_d     = n_in_s;
          msb_d   = stream.in_msb_first;
          idx_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && last_s) begin
          if (stream.in_valid) begin
            state_d = SEND;
            word_d  = stream.in_data;
            n_d     = n_in_s;
            msb_d   = stream.in_msb_first;
            idx_d   = {CNT_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end else if (xfer_s) begin
          idx_d = idx_q + CNT_W'(1'b1);
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef WORD_SERIALIZER_PARITY_EN
  logic [SEL_W-1:0]  sel_nxt_s;
  logic [LANE_W-1:0] lane_nxt_s;
  logic              par_d;
  logic              par_q;

  function automatic logic lane_parity(input logic [LANE_W-1:0] d);
    return ^d;
  endfunction

  assign sel_nxt_s = lane_sel(msb_d, n_d, idx_d);

  lane_mux #(
    .LANE_W (LANE_W),
    .LANES  (LANES),
    .SEL_W  (SEL_W)
  ) u_lane_mux_nxt (
    .data_i (word_d),
    .sel_i  (sel_nxt_s),
    .lane_o (lane_nxt_s)
  );

  assign par_d = (state_d == SEND) ? lane_parity(lane_nxt_s) : 1'b0;

  // Parity of the lane that will be presented next cycle, so it lines up with out_data.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: stimulus pushes expected lanes, a negedge
// monitor compares every presented lane and pops on transfer.
module tb_word_serializer;

  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = 16;
  localparam int unsigned CNT_W  = 5;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic nRst;
  logic busy;
`ifdef WORD_SERIALIZER_PARITY_EN
  logic out_parity;
`endif

  exp_t q[$];
  int   chk_cnt  = 0;
  int   fail_cnt = 0;
  logic [LANES*LANE_W-1:0] pattern;

  word_serializer_if #(.LANE_W(LANE_W), .LANES(LANES), .CNT_W(CNT_W)) sif ();

  word_serializer #(.LANE_W(LANE_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .stream     (sif),
`ifdef WORD_SERIALIZER_PARITY_EN
    .out_parity (out_parity),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented lane must match the scoreboard head.
  always @(negedge clk) begin
    if (nRst && sif.out_valid) begin
      check("lane_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        check("out_data", 32'(sif.out_data), 32'(q[0].data));
        check("out_last", 32'(sif.out_last), 32'(q[0].last));
        check("in_ready_in_send", 32'(sif.in_ready), 32'(sif.out_ready & q[0].last));
        check("busy_in_send", 32'(busy), 32'd1);
`ifdef WORD_SERIALIZER_PARITY_EN
        check("out_parity", 32'(out_parity), 32'(^q[0].data));
`endif
        if (sif.out_ready) begin
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic push_word(input int cnt, input bit msb);
    int n;
    n = ((cnt == 0) || (cnt > int'(LANES))) ? int'(LANES) : cnt;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = 8'(msb ? (n - 1 - i) : i);
      e.last = (i == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic send_word(input int cnt, input bit msb, input bit keep);
    bit ok;
    push_word(cnt, msb);
    sif.in_data      = pattern;
    sif.in_count     = CNT_W'(cnt);
    sif.in_msb_first = msb;
    sif.in_valid     = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (sif.in_ready) ok = 1'b1;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) sif.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 200 && q.size() != 0; c++) begin
      @(negedge clk);
    end
    check(name, 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stall;
    for (int k = 0; k < int'(LANES); k++) pattern[k*LANE_W +: LANE_W] = 8'(k);
    nRst             = 1'b0;
    sif.in_valid     = 1'b0;
    sif.in_data      = '0;
    sif.in_count     = 5'd0;
    sif.in_msb_first = 1'b0;
    sif.out_ready    = 1'b1;

    #3;
    check("rst_in_ready",  32'(sif.in_ready),  32'd1);
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_out_last",  32'(sif.out_last),  32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_out_data",  32'(sif.out_data),  32'd0);
`ifdef WORD_SERIALIZER_PARITY_EN
    check("rst_out_parity", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);
    nRst = 1'b1;
    @(posedge clk);
    #1;

    // LSB-first, full word via count 0
    send_word(0, 1'b0, 1'b0);
    drain("full_lsb_drain");
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(sif.in_ready), 32'd1);

    // MSB-first partial word
    send_word(4, 1'b1, 1'b0);
    drain("msb4_drain");

    // Backpressure on the second lane
    send_word(3, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sif.out_ready = 1'b0;
    stall = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (sif.out_valid && !sif.out_ready) stall++;
      check("stall_data", 32'(sif.out_data), 32'h01);
      check("stall_last", 32'(sif.out_last), 32'd0);
    end
    check("stall_cycles", 32'(stall), 32'd5);
    @(posedge clk);
    #1;
    sif.out_ready = 1'b1;
    drain("bp_drain");

    // Back-to-back: A (N=2, lsb) then B (N=2, msb) with in_valid held
    send_word(2, 1'b0, 1'b1);
    push_word(2, 1'b1);
    sif.in_count     = 5'd2;
    sif.in_msb_first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_valid", 32'(sif.out_valid), 32'd1);
      check("b2b_in_ready", 32'(sif.in_ready), 32'((i == 1) || (i == 3)));
      @(posedge clk);
      #1;
      if (i == 1) sif.in_valid = 1'b0;
    end
    drain("b2b_drain");
    check("b2b_idle", 32'(busy), 32'd0);

    // Edge counts: single lane msb-first, then clamp of 20 to 16
    send_word(1, 1'b1, 1'b0);
    drain("n1_drain");
    send_word(20, 1'b0, 1'b0);
    drain("clamp_drain");

    // Reset during lane 5 of 16
    send_word(0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    nRst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),          32'd0);
    check("mid_rst_in_ready",  32'(sif.in_ready),  32'd1);
    check("mid_rst_pending",   32'(q.size()),      32'd11);
    q.delete();
    #4;
    nRst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_lane", 32'(sif.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send_word(2, 1'b0, 1'b0);
    drain("post_rst_drain");

    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
